// File: rtl/ofm_tiling_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ofm_tiling_scheduler
// Description : Steps the OFM read-address controller through every tile of
//               one layer. Issues one start pulse per layer and one load pulse
//               per tile. Drives the 1-based tile index and that index modulo
//               the OFM edge size. Detects tile completion from the falling
//               edge of the reader's read_en. Holds each new load until the
//               systolic array reports ready.
// Ports       : clk, rst_n              clock, async active-low reset
//               layer_start, abort      layer control from the layer sequencer
//               num_tiling, ofm_size    layer configuration (latched at start)
//               pe_ready                systolic array can accept a tile
//               rd_en                   read_en from the OFM reader
//               rd_start, rd_load       control pulses to the OFM reader
//               count_tiling,
//               count_tiling_mod_ofm_size  tile index outputs to the reader
//               tile_done, layer_done   completion pulses
//               busy                    scheduler is not idle
// Revision    : 1.0  initial release
// ============================================================================
module ofm_tiling_scheduler #(
    parameter int GAP_CYCLES = 2,
    parameter int TILE_W     = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              layer_start,
    input  logic              abort,
    input  logic [TILE_W-1:0] num_tiling,
    input  logic [8:0]        ofm_size,
    input  logic              pe_ready,
    input  logic              rd_en,
    output logic              rd_start,
    output logic              rd_load,
    output logic [TILE_W-1:0] count_tiling,
    output logic [8:0]        count_tiling_mod_ofm_size,
    output logic              tile_done,
    output logic              layer_done,
    output logic              busy
);

    // The gap counter only has to hold GAP_CYCLES-1.
    localparam int c_gap_w = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [c_gap_w-1:0] c_gap_load = c_gap_w'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INIT      = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_RD_HI = 3'd3,
        ST_WAIT_RD_LO = 3'd4,
        ST_GAP       = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [TILE_W-1:0]   num_q, num_d;
    logic [8:0]          ofm_q, ofm_d;
    logic [TILE_W-1:0]   cnt_q, cnt_d;
    logic [8:0]          mod_q, mod_d;
    logic [c_gap_w-1:0]  gap_q, gap_d;
    logic                rd_start_q, rd_start_d;
    logic                rd_load_q, rd_load_d;
    logic                tile_done_q, tile_done_d;
    logic                layer_done_q, layer_done_d;
    logic                busy_q, busy_d;

    always_comb begin
        state_d      = state_q;
        num_d        = num_q;
        ofm_d        = ofm_q;
        cnt_d        = cnt_q;
        mod_d        = mod_q;
        gap_d        = gap_q;
        rd_start_d   = 1'b0;
        rd_load_d    = 1'b0;
        tile_done_d  = 1'b0;
        layer_done_d = 1'b0;

        if (abort) begin
            // Abort wins over everything; counters keep their last values.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (layer_start) begin
                        num_d      = num_tiling;
                        ofm_d      = ofm_size;
                        cnt_d      = TILE_W'(1);
                        mod_d      = (ofm_size == 9'd1) ? 9'd0 : 9'd1;
                        rd_start_d = 1'b1;
                        state_d    = ST_INIT;
                    end
                end
                ST_INIT: begin
                    state_d = (num_q == '0) ? ST_DONE : ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (pe_ready) begin
                        rd_load_d = 1'b1;
                        state_d   = ST_WAIT_RD_HI;
                    end
                end
                ST_WAIT_RD_HI: begin
                    if (rd_en) begin
                        state_d = ST_WAIT_RD_LO;
                    end
                end
                ST_WAIT_RD_LO: begin
                    // Falling read_en marks the end of the current tile.
                    if (!rd_en) begin
                        tile_done_d = 1'b1;
                        if (cnt_q == num_q) begin
                            state_d = ST_DONE;
                        end else begin
                            cnt_d   = cnt_q + TILE_W'(1);
                            mod_d   = (mod_q == ofm_q - 9'd1) ? 9'd0 : mod_q + 9'd1;
                            gap_d   = c_gap_load;
                            state_d = ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_q == '0) begin
                        state_d = ST_ISSUE;
                    end else begin
                        gap_d = gap_q - c_gap_w'(1);
                    end
                end
                ST_DONE: begin
                    layer_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Registered so busy tracks the state register exactly.
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            num_q        <= '0;
            ofm_q        <= '0;
            cnt_q        <= '0;
            mod_q        <= '0;
            gap_q        <= '0;
            rd_start_q   <= 1'b0;
            rd_load_q    <= 1'b0;
            tile_done_q  <= 1'b0;
            layer_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_q        <= num_d;
            ofm_q        <= ofm_d;
            cnt_q        <= cnt_d;
            mod_q        <= mod_d;
            gap_q        <= gap_d;
            rd_start_q   <= rd_start_d;
            rd_load_q    <= rd_load_d;
            tile_done_q  <= tile_done_d;
            layer_done_q <= layer_done_d;
            busy_q       <= busy_d;
        end
    end

    assign rd_start                  = rd_start_q;
    assign rd_load                   = rd_load_q;
    assign count_tiling              = cnt_q;
    assign count_tiling_mod_ofm_size = mod_q;
    assign tile_done                 = tile_done_q;
    assign layer_done                = layer_done_q;
    assign busy                      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ofm_tiling_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ofm_tiling_scheduler
// Description : Directed self-checking bench for ofm_tiling_scheduler with a
//               behavioural OFM reader (read_en high for 10 cycles per load).
// Revision    : 1.0  initial release
// ============================================================================
module tb_ofm_tiling_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        layer_start = 1'b0;
    logic        abort = 1'b0;
    logic [13:0] num_tiling = '0;
    logic [8:0]  ofm_size = '0;
    logic        pe_ready = 1'b1;
    logic        rd_en = 1'b0;
    logic        rd_start, rd_load, tile_done, layer_done, busy;
    logic [13:0] count_tiling;
    logic [8:0]  count_mod;

    ofm_tiling_scheduler #(
        .GAP_CYCLES (3),
        .TILE_W     (14)
    ) u_dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .layer_start               (layer_start),
        .abort                     (abort),
        .num_tiling                (num_tiling),
        .ofm_size                  (ofm_size),
        .pe_ready                  (pe_ready),
        .rd_en                     (rd_en),
        .rd_start                  (rd_start),
        .rd_load                   (rd_load),
        .count_tiling              (count_tiling),
        .count_tiling_mod_ofm_size (count_mod),
        .tile_done                 (tile_done),
        .layer_done                (layer_done),
        .busy                      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reader model: read_en high for 10 cycles after each load pulse.
    int fall_cyc = -100;
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rd_load) begin
                rd_en = 1'b1;
                repeat (10) begin @(posedge clk); #1; end
                rd_en = 1'b0;
                fall_cyc = cyc;
            end
        end
    end

    // Monitor: event counts and per-load snapshots.
    int n_start = 0, n_load = 0, n_tdone = 0, n_ldone = 0;
    int start_cyc = 0, tdone_cyc = 0, ldone_cyc = 0;
    int load_cnt[64], load_mod[64], load_at[64], load_gap[64];
    always @(negedge clk) begin
        if (rd_start) begin n_start++; start_cyc = cyc; end
        if (rd_load) begin
            if (n_load < 64) begin
                load_cnt[n_load] = int'(count_tiling);
                load_mod[n_load] = int'(count_mod);
                load_at[n_load]  = cyc;
                load_gap[n_load] = cyc - fall_cyc;
            end
            n_load++;
        end
        if (tile_done)  begin n_tdone++; tdone_cyc = cyc; end
        if (layer_done) begin n_ldone++; ldone_cyc = cyc; end
    end

    int ls_cyc = 0;

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic start_layer(input int nt, input int os);
        tick();
        num_tiling  = 14'(nt);
        ofm_size    = 9'(os);
        layer_start = 1'b1;
        ls_cyc      = cyc;
        tick();
        layer_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int base, input int max);
        int k;
        k = 0;
        while (n_ldone == base && k < max) begin tick(); k++; end
        check(tag, n_ldone - base, 1);
    endtask

    task automatic wait_loads(input int target, input int max);
        int k;
        k = 0;
        while (n_load < target && k < max) begin tick(); k++; end
    endtask

    initial begin
        int b_ld, b_load, b_st, b_td, bad, pr_cyc, k;

        // Reset state
        repeat (3) tick();
        check("reset_outputs", int'({rd_start, rd_load, count_tiling, count_mod,
                                     tile_done, layer_done, busy}), 0);
        rst_n = 1'b1;
        repeat (2) tick();
        check("idle_outputs", int'({rd_start, rd_load, count_tiling, count_mod,
                                    tile_done, layer_done, busy}), 0);

        // 3 tiles, ofm_size 2
        b_ld = n_ldone; b_load = n_load; b_st = n_start; b_td = n_tdone;
        start_layer(3, 2);
        check("t1_busy", int'(busy), 1);
        wait_done("t1_layer_done", b_ld, 300);
        check("t1_rd_start_count", n_start - b_st, 1);
        check("t1_rd_load_count", n_load - b_load, 3);
        check("t1_count_seq", load_cnt[b_load] * 100 + load_cnt[b_load+1] * 10
                              + load_cnt[b_load+2], 123);
        check("t1_mod_seq", load_mod[b_load] * 100 + load_mod[b_load+1] * 10
                            + load_mod[b_load+2], 101);
        check("t1_tile_done_count", n_tdone - b_td, 3);
        check("t1_fall_to_tile_done", tdone_cyc - fall_cyc, 1);
        check("t1_fall_to_layer_done", ldone_cyc - fall_cyc, 2);
        check("t1_gap_ge4", int'(load_gap[b_load+1] >= 4 && load_gap[b_load+2] >= 4), 1);
        check("t1_busy_after", int'(busy), 0);

        // ofm_size 1, 4 tiles
        b_ld = n_ldone; b_load = n_load;
        start_layer(4, 1);
        wait_done("t2_layer_done", b_ld, 300);
        check("t2_rd_load_count", n_load - b_load, 4);
        check("t2_mod_all_zero", load_mod[b_load] + load_mod[b_load+1]
                                 + load_mod[b_load+2] + load_mod[b_load+3], 0);
        check("t2_last_count", load_cnt[b_load+3], 4);

        // pe_ready low for 20 cycles before tile 2
        b_ld = n_ldone; b_load = n_load; b_td = n_tdone;
        start_layer(2, 3);
        k = 0;
        while (n_tdone == b_td && k < 100) begin tick(); k++; end
        pe_ready = 1'b0;
        bad = 0;
        repeat (20) begin
            tick();
            if (rd_load || count_tiling != 14'd2) bad++;
        end
        pe_ready = 1'b1;
        pr_cyc = cyc;
        wait_done("t3_layer_done", b_ld, 100);
        check("t3_hold_while_not_ready", bad, 0);
        check("t3_load_after_ready", load_at[b_load+1] - pr_cyc, 1);
        check("t3_tile2_count", load_cnt[b_load+1], 2);
        check("t3_tile2_mod", load_mod[b_load+1], 2);

        // num_tiling 0
        b_ld = n_ldone; b_load = n_load; b_st = n_start;
        start_layer(0, 5);
        wait_done("t4_layer_done", b_ld, 20);
        check("t4_rd_start_count", n_start - b_st, 1);
        check("t4_rd_start_latency", start_cyc - ls_cyc, 1);
        check("t4_layer_done_latency", ldone_cyc - ls_cyc, 3);
        check("t4_no_load", n_load - b_load, 0);

        // abort in WAIT_RD_LO of tile 2
        b_ld = n_ldone; b_load = n_load; b_td = n_tdone;
        start_layer(3, 2);
        wait_loads(b_load + 2, 200);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_busy_after_abort", int'(busy), 0);
        check("t5_count_held", int'(count_tiling), 2);
        repeat (20) tick();
        check("t5_tile_done_count", n_tdone - b_td, 1);
        check("t5_no_layer_done", n_ldone - b_ld, 0);
        check("t5_no_more_loads", n_load - b_load, 2);
        b_ld = n_ldone; b_load = n_load;
        start_layer(2, 2);
        wait_done("t5_restart_done", b_ld, 200);
        check("t5_restart_count", load_cnt[b_load], 1);
        check("t5_restart_loads", n_load - b_load, 2);

        // layer_start while busy is ignored
        b_ld = n_ldone; b_load = n_load; b_st = n_start;
        start_layer(2, 3);
        wait_loads(b_load + 1, 100);
        start_layer(5, 1);
        wait_done("t6_layer_done", b_ld, 200);
        check("t6_loads", n_load - b_load, 2);
        check("t6_starts", n_start - b_st, 1);
        check("t6_mod_kept", load_mod[b_load+1], 2);

        // async reset mid-tile
        b_ld = n_ldone; b_load = n_load; b_td = n_tdone;
        start_layer(3, 2);
        wait_loads(b_load + 1, 100);
        repeat (2) tick();
        check("t7_count_before_reset", int'(count_tiling), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t7_async_clear", int'({rd_start, rd_load, count_tiling, count_mod,
                                      tile_done, layer_done, busy}), 0);
        tick();
        rst_n = 1'b1;
        repeat (30) tick();
        check("t7_no_tile_done", n_tdone - b_td, 0);
        check("t7_no_layer_done", n_ldone - b_ld, 0);
        check("t7_idle", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
